// File: rtl/cu_pkg.sv
// Shared ControlUnit definitions: sequencer state encoding, default sizes and
// the one-hot step constants for the default four-step M-cycle.
package cu_pkg;

    localparam int STEPS_DEF   = 4;
    localparam int COUNT_W_DEF = 8;

    localparam logic [STEPS_DEF-1:0] STEP_FIRST = 4'b0001;
    localparam logic [STEPS_DEF-1:0] STEP_LAST  = 4'b1000;

    typedef enum logic [1:0] {
        BOOT = 2'b00,
        RUN  = 2'b01,
        HALT = 2'b10
    } cu_state_t;

endpackage

// File: rtl/mcycle_sequencer_onehot_ring.sv
// onehot_ring: one-hot rotating register. Resets and loads to bit 0,
// rotates left one position per enabled clock, holds otherwise.
module onehot_ring #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    output logic [WIDTH-1:0] ring
);

    localparam logic [WIDTH-1:0] BIT0 = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] ring_r;

    // Ring register: load has priority so a corrupted pattern is repaired at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring_r <= BIT0;
        end else if (load) begin
            ring_r <= BIT0;
        end else if (en) begin
            ring_r <= {ring_r[WIDTH-2:0], ring_r[WIDTH-1]};
        end else begin
            ring_r <= ring_r;
        end
    end

    assign ring = ring_r;

endmodule

// File: rtl/mcycle_sequencer.sv
// mcycle_sequencer: generates the one-hot T-step and M-cycle vectors for the
// microcode blocks, ends instructions on i_IR_Fetch, strobes the IR load, and
// handles boot fetch, wait stalls, HALT and runaway-instruction recovery.
// Optional build macro MCYCLE_SEQUENCER_TRACE_EN adds o_Instr_Cycles/o_Retired.
module mcycle_sequencer
    import cu_pkg::*;
#(
    parameter int STEPS   = STEPS_DEF,
    parameter int COUNT_W = COUNT_W_DEF
) (
    input  logic               i_Clk,
    input  logic               i_Reset,
    input  logic               i_Wait,
    input  logic               i_IR_Fetch,
    input  logic               i_Halt,
    input  logic               i_Wake,
    output logic [STEPS-1:0]   o_Cycle_Step,
    output logic [COUNT_W-1:0] o_Cycle_Count,
    output logic               o_Boot_Fetch,
    output logic               o_IR_Load,
    output logic               o_Halted,
`ifdef MCYCLE_SEQUENCER_TRACE_EN
    output logic [7:0]         o_Instr_Cycles,
    output logic [31:0]        o_Retired,
`endif
    output logic               o_Overrun
);

    localparam logic [STEPS-1:0]   STEP_ONE    = {{(STEPS-1){1'b0}}, 1'b1};
    localparam logic [COUNT_W-1:0] COUNT_FIRST = {{(COUNT_W-1){1'b0}}, 1'b1};

    cu_state_t          state_r;
    cu_state_t          next_state_s;
    logic [COUNT_W-1:0] count_r;
    logic [COUNT_W-1:0] next_count_s;
    logic               overrun_r;
    logic               next_overrun_s;
    logic [STEPS-1:0]   step_s;
    logic               step_bad_s;
    logic               boundary_s;
    logic               ir_load_s;

    // A step vector that is zero or has more than one bit set is forced back to bit 0.
    always_comb begin
        step_bad_s = (step_s == '0) || ((step_s & (step_s - STEP_ONE)) != '0);
    end

    onehot_ring #(
        .WIDTH (STEPS)
    ) u_step_ring (
        .clk  (i_Clk),
        .rst  (i_Reset),
        .en   (~i_Wait),
        .load (step_bad_s),
        .ring (step_s)
    );

    assign boundary_s = step_s[STEPS-1] & ~i_Wait;

    // State, M-cycle count and sticky overrun registers.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_r   <= BOOT;
            count_r   <= '0;
            overrun_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            count_r   <= next_count_s;
            overrun_r <= next_overrun_s;
        end
    end

    // Next-state decode; every decision is taken only at an M-cycle boundary.
    always_comb begin
        next_state_s   = state_r;
        next_count_s   = count_r;
        next_overrun_s = overrun_r;
        ir_load_s      = 1'b0;
        case (state_r)
            BOOT: begin
                if (boundary_s) begin
                    ir_load_s    = 1'b1;
                    next_count_s = COUNT_FIRST;
                    next_state_s = RUN;
                end else begin
                    next_count_s = '0;
                end
            end
            RUN: begin
                if (boundary_s) begin
                    if (i_IR_Fetch) begin
                        if (i_Halt) begin
                            next_count_s = '0;
                            next_state_s = HALT;
                        end else begin
                            ir_load_s    = 1'b1;
                            next_count_s = COUNT_FIRST;
                        end
                    end else if (count_r[COUNT_W-1]) begin
                        // Runaway instruction: flag it and recover through a boot fetch.
                        next_overrun_s = 1'b1;
                        next_count_s   = '0;
                        next_state_s   = BOOT;
                    end else begin
                        next_count_s = {count_r[COUNT_W-2:0], 1'b0};
                    end
                end else begin
                    next_count_s = count_r;
                end
            end
            HALT: begin
                next_count_s = '0;
                if (boundary_s && i_Wake) begin
                    next_state_s = BOOT;
                end else begin
                    next_state_s = HALT;
                end
            end
            default: begin
                next_state_s = BOOT;
                next_count_s = '0;
            end
        endcase
    end

    assign o_Cycle_Step  = step_s;
    assign o_Cycle_Count = count_r;
    assign o_Boot_Fetch  = (state_r == BOOT);
    assign o_Halted      = (state_r == HALT);
    assign o_IR_Load     = ir_load_s;
    assign o_Overrun     = overrun_r;

`ifdef MCYCLE_SEQUENCER_TRACE_EN
    logic [7:0]  instr_cycles_r;
    logic [31:0] retired_r;

    // Converts the one-hot M-cycle index to the number of M-cycles used (1-based).
    function automatic logic [7:0] cycles_of(input logic [COUNT_W-1:0] c);
        logic [7:0] n;
        n = 8'd0;
        for (int i = 0; i < COUNT_W; i++) begin
            if (c[i]) begin
                n = 8'(i + 1);
            end else begin
                n = n;
            end
        end
        return n;
    endfunction

    // Trace counters: instruction length on each load from RUN, wrapping load count.
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            instr_cycles_r <= 8'd0;
            retired_r      <= 32'd0;
        end else if (ir_load_s) begin
            retired_r <= retired_r + 32'd1;
            if (state_r == RUN) begin
                instr_cycles_r <= cycles_of(count_r);
            end else begin
                instr_cycles_r <= instr_cycles_r;
            end
        end else begin
            instr_cycles_r <= instr_cycles_r;
            retired_r      <= retired_r;
        end
    end

    assign o_Instr_Cycles = instr_cycles_r;
    assign o_Retired      = retired_r;
`endif

endmodule

// File: tb/tb_mcycle_sequencer.sv
// Testbench for mcycle_sequencer: a vector table for boot, multi-cycle
// instructions, wait stalls and HALT/wake, plus hand sequences for overrun,
// reset mid-instruction and (when built with MCYCLE_SEQUENCER_TRACE_EN) tracing.
module tb_mcycle_sequencer;

    logic       clk;
    logic       rst;
    logic       wait_in;
    logic       fetch;
    logic       halt;
    logic       wake;
    logic [3:0] step;
    logic [7:0] count;
    logic       boot_fetch;
    logic       ir_load;
    logic       halted;
    logic       overrun;
`ifdef MCYCLE_SEQUENCER_TRACE_EN
    logic [7:0]  instr_cycles;
    logic [31:0] retired;
    logic [31:0] retired_before;
`endif

    int errors = 0;
    int checks = 0;

    mcycle_sequencer #(
        .STEPS   (4),
        .COUNT_W (8)
    ) dut (
        .i_Clk          (clk),
        .i_Reset        (rst),
        .i_Wait         (wait_in),
        .i_IR_Fetch     (fetch),
        .i_Halt         (halt),
        .i_Wake         (wake),
        .o_Cycle_Step   (step),
        .o_Cycle_Count  (count),
        .o_Boot_Fetch   (boot_fetch),
        .o_IR_Load      (ir_load),
        .o_Halted       (halted),
`ifdef MCYCLE_SEQUENCER_TRACE_EN
        .o_Instr_Cycles (instr_cycles),
        .o_Retired      (retired),
`endif
        .o_Overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       w;
        logic       f;
        logic       h;
        logic       k;
        logic [3:0] e_step;
        logic [7:0] e_count;
        logic       e_boot;
        logic       e_load;
        logic       e_halted;
        logic       e_ovr;
    } vec_t;

    vec_t vecs[29];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic w, input logic f, input logic h, input logic k);
        wait_in = w;
        fetch   = f;
        halt    = h;
        wake    = k;
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wait_in = 1'b0; fetch = 1'b0; halt = 1'b0; wake = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        //          w     f     h     k     step     count         boot  load  halt  ovr
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b0010, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'b0100, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b0100, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'b1000, 8'b00000010, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'b1000, 8'b00000010, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 4'b1000, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[21] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b0010, 8'b00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1000, 8'b00000000, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0100, 8'b00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b1000, 8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 8'b00000001, 1'b0, 1'b0, 1'b0, 1'b0};

        do_reset();

        // Table: boot, two-cycle instruction, wait stall, HALT and wake.
        for (int i = 0; i < 29; i++) begin
            drive(vecs[i].w, vecs[i].f, vecs[i].h, vecs[i].k);
            chk($sformatf("v%0d_step", i),   {28'd0, step},       {28'd0, vecs[i].e_step});
            chk($sformatf("v%0d_count", i),  {24'd0, count},      {24'd0, vecs[i].e_count});
            chk($sformatf("v%0d_boot", i),   {31'd0, boot_fetch}, {31'd0, vecs[i].e_boot});
            chk($sformatf("v%0d_load", i),   {31'd0, ir_load},    {31'd0, vecs[i].e_load});
            chk($sformatf("v%0d_halted", i), {31'd0, halted},     {31'd0, vecs[i].e_halted});
            chk($sformatf("v%0d_ovr", i),    {31'd0, overrun},    {31'd0, vecs[i].e_ovr});
            tick();
        end

        // Overrun: eight M-cycles without i_IR_Fetch.
        do_reset();
        ticks(4);
        for (int m = 0; m < 8; m++) begin
            for (int s = 0; s < 4; s++) begin
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                chk("ovr_count", {24'd0, count}, {24'd0, 8'(1 << m)});
                chk("ovr_step",  {28'd0, step},  {28'd0, 4'(1 << s)});
                chk("ovr_load",  {31'd0, ir_load}, 32'd0);
                if (m == 7 && s == 3) chk("ovr_pre", {31'd0, overrun}, 32'd0);
                tick();
            end
        end
        chk("ovr_set",   {31'd0, overrun},    32'd1);
        chk("ovr_boot",  {31'd0, boot_fetch}, 32'd1);
        chk("ovr_cnt0",  {24'd0, count},      32'd0);
        chk("ovr_step0", {28'd0, step},       32'd1);
        ticks(3);
        chk("ovr_bootload", {31'd0, ir_load}, 32'd1);
        tick();
        chk("ovr_run_cnt", {24'd0, count}, 32'd1);
        ticks(3);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("ovr_next_load", {31'd0, ir_load}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("ovr_sticky", {31'd0, overrun}, 32'd1);
        chk("ovr_new_cnt", {24'd0, count},  32'd1);
        do_reset();
        chk("ovr_cleared", {31'd0, overrun}, 32'd0);

        // Reset mid-instruction at count 00000100, step 0010.
        ticks(4 + 4 + 4 + 1);
        chk("mid_count", {24'd0, count}, 32'h04);
        chk("mid_step",  {28'd0, step},  32'h2);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_step",   {28'd0, step},       32'h1);
        chk("rst_count",  {24'd0, count},      32'd0);
        chk("rst_boot",   {31'd0, boot_fetch}, 32'd1);
        chk("rst_load",   {31'd0, ir_load},    32'd0);
        chk("rst_halted", {31'd0, halted},     32'd0);
        chk("rst_ovr",    {31'd0, overrun},    32'd0);
        tick();
        chk("rst_hold_step", {28'd0, step},    32'h1);
        chk("rst_hold_load", {31'd0, ir_load}, 32'd0);
        rst = 1'b0;

`ifdef MCYCLE_SEQUENCER_TRACE_EN
        // Trace: boot load then a three-cycle instruction.
        do_reset();
        chk("tr_rst_cycles",  {24'd0, instr_cycles}, 32'd0);
        chk("tr_rst_retired", retired,               32'd0);
        ticks(4);
        chk("tr_boot_retired", retired,               32'd1);
        chk("tr_boot_cycles",  {24'd0, instr_cycles}, 32'd0);
        retired_before = retired;
        ticks(4 + 4 + 3);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("tr_load", {31'd0, ir_load}, 32'd1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("tr_cycles3", {24'd0, instr_cycles}, 32'd3);
        chk("tr_retired", retired, retired_before + 32'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mcycle_sequencer.md
Name: mcycle_sequencer

Overview:
- Timing generator that drives the one-hot T-step (i_Cycle_Step) and M-cycle (i_Cycle_Count) vectors consumed by every per-opcode microcode block.
- Consumes the OR'd o_IR_Fetch returned by the microcode blocks to decide when the current instruction ends, and strobes the instruction-register load.
- Sits in the ControlUnit between the clock/wait logic and the microcode decoders. Handles boot fetch, memory wait stalls, HALT, and runaway-instruction recovery.

Parameters:
- STEPS, 4, T-steps per M-cycle (width of o_Cycle_Step).
- COUNT_W, 8, maximum M-cycles per instruction (width of o_Cycle_Count).

Ports:
- i_Clk  input  1  system clock; all state changes on rising edge.
- i_Reset  input  1  asynchronous, active-high reset.
- i_Wait  input  1  memory wait; holds all state while high.
- i_IR_Fetch  input  1  OR of all microcode o_IR_Fetch; current M-cycle is the last one of the instruction.
- i_Halt  input  1  decoded HALT opcode is executing.
- i_Wake  input  1  interrupt pending; exits HALT.
- o_Cycle_Step  output  STEPS  one-hot T-step.
- o_Cycle_Count  output  COUNT_W  one-hot M-cycle index; all-zero during BOOT/HALT.
- o_Boot_Fetch  output  1  opcode-fetch control while no instruction is decoded.
- o_IR_Load  output  1  one-clock strobe; IR latches bus data.
- o_Halted  output  1  in HALT state.
- o_Overrun  output  1  sticky error flag; COUNT_W exceeded.

Behaviour:
- Reset values: step=0001, count=00000000, state BOOT, o_Boot_Fetch=1, o_IR_Load=0, o_Halted=0, o_Overrun=0.
- Step rotation: each clock with i_Wait=0, step rotates left: 0001→0010→0100→1000→0001. With i_Wait=1, step, count and state are frozen, and o_IR_Load is forced 0.
- The end of an M-cycle is step[STEPS-1] with i_Wait=0, called the "boundary".
- States:
  - BOOT: count=0, o_Boot_Fetch=1. At boundary: o_IR_Load=1 (combinational, that clock only), count←bit0, go RUN.
  - RUN: o_Boot_Fetch=0.
    - At boundary with i_IR_Fetch=1 and i_Halt=0: o_IR_Load=1, count←bit0 (new instruction starts).
    - At boundary with i_IR_Fetch=1 and i_Halt=1: o_IR_Load=0, count←0, go HALT.
    - At boundary with i_IR_Fetch=0: count shifts left one.
    - If count=bit(COUNT_W-1) at boundary with i_IR_Fetch=0: o_Overrun←1 (sticky until reset), then behave as BOOT (count←0, next M-cycle is a boot fetch).
  - HALT: count=0, o_Halted=1, steps keep rotating. At boundary with i_Wake=1: go BOOT (the fetch is performed by BOOT). i_Wake outside a boundary is ignored until the next boundary.
- i_IR_Fetch and i_Halt are sampled only at the boundary; glitches mid-cycle have no effect.
- Output sourcing: count/step outputs are registered. o_IR_Load, o_Boot_Fetch and o_Halted decode combinationally from state and step.
- Reset mid-instruction: immediate return to the reset values; no o_IR_Load pulse.
- Invariant: exactly one step bit is set at all times. Count is one-hot or zero.

Optional Feature:
- Macro: MCYCLE_SEQUENCER_TRACE_EN.
- Defined: adds output o_Instr_Cycles [7:0] and a 32-bit output o_Retired.
  - o_Instr_Cycles: M-cycles used by the last completed instruction (1..COUNT_W), updated on each o_IR_Load from RUN; reset 0.
  - o_Retired: wrapping count of o_IR_Load pulses; reset 0; wraps FFFFFFFF→0.
- Undefined: ports absent, no extra registers.

Decomposition:
- Shared package cu_pkg holds:
  - state enum {BOOT, RUN, HALT} (2-bit encoding 00/01/10),
  - STEP_FIRST/STEP_LAST one-hot constants,
  - COUNT_W default.
- One sub-module is natural: onehot_ring, a parameterised one-hot rotating register with enable and load-to-bit0, instanced for the step vector.

Test Plan:
- Boot: release reset → step 0001,0010,0100,1000; o_Boot_Fetch=1 throughout; o_IR_Load=1 on step 1000 only; next clock count=00000001.
- Two-cycle instruction: i_IR_Fetch=1 during count=00000010 → o_IR_Load at its step 1000; count returns to 00000001; no pulse at the end of count 00000001.
- Wait stall: i_Wait=1 for 3 clocks at step 0100, count 00000010 → outputs frozen 3 clocks, o_IR_Load stays 0, then resume at 1000.
- HALT: i_Halt=1, i_IR_Fetch=1 at boundary → o_Halted=1, count=0; i_Wake at step 0010 ignored until step 1000, then BOOT fetch with o_IR_Load pulse.
- Overrun: hold i_IR_Fetch=0 for 8 M-cycles → count reaches 10000000; at its boundary o_Overrun=1 and state goes to BOOT; o_Overrun stays 1 through later instructions until reset.
- Reset mid-instruction: assert i_Reset at count 00000100, step 0010 → outputs immediately equal the reset values; no o_IR_Load. With TRACE_EN defined: a 3-cycle instruction gives o_Instr_Cycles=3, and o_Retired increments by 1.
